pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Stall/flush companion to the ALU data forwarding unit. Forwarding resolves RAW hazards by steering later-stage results into EX. This block handles the cases forwarding cannot resolve:
  - load-use bubbles;
  - data-memory wait freezes;
  - taken-branch flushes.
- Drives the hold/bubble/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Includes a memory-wait timeout watchdog and saturating hazard performance counters.

Parameters:
- REG_ADDR_W, 5, register index width.
- TIMEOUT, 64, maximum consecutive memory-wait cycles before error (legal range 2..2^16-1).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- ID_Rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
- ID_Rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
- ID_UsesRs1  in  1  ID instruction reads Rs1.
- ID_UsesRs2  in  1  ID instruction reads Rs2.
- EX_MemRead  in  1  EX instruction is a load.
- EX_Rd  in  REG_ADDR_W  destination register of the EX instruction.
- EX_BranchTaken  in  1  EX resolved a taken branch or jump.
- MEM_MemReq  in  1  MEM stage has an active data-memory access.
- MEM_MemReady  in  1  data memory completes the access this cycle.
- cnt_clear  in  1  synchronous clear of all performance counters.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID register keeps its value.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_hold  out  1  ID/EX register keeps its value.
- idex_bubble  out  1  ID/EX register loads a NOP.
- exmem_hold  out  1  EX/MEM register keeps its value.
- memwb_bubble  out  1  MEM/WB register loads a NOP.
- mem_timeout  out  1  sticky watchdog error.
- load_use_cnt  out  CNT_W  count of load-use bubbles.
- mem_stall_cnt  out  CNT_W  count of memory-wait cycles.
- flush_cnt  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Reset (async, rst=1): state=RUN, wait counter=0, mem_timeout=0, all counters=0.
- All control outputs are combinational from state plus inputs. They are 0 whenever rst=1.
- load_use = EX_MemRead & EX_Rd!=0 & ((ID_UsesRs1 & ID_Rs1==EX_Rd) | (ID_UsesRs2 & ID_Rs2==EX_Rd)).
- mem_wait = MEM_MemReq & ~MEM_MemReady.
- States: RUN, MEM_WAIT, HALT.
- RUN, priority order (highest first):
  1. mem_wait: pc_hold=ifid_hold=idex_hold=exmem_hold=memwb_bubble=1, no other control asserted. Next state MEM_WAIT, wait counter=1.
  2. EX_BranchTaken: ifid_flush=idex_bubble=1, pc not held, load_use ignored. flush_cnt+1.
  3. load_use: pc_hold=ifid_hold=idex_bubble=1, exactly one cycle (the next cycle sees the bubble in EX). load_use_cnt+1.
  4. Otherwise all controls 0.
- MEM_WAIT:
  - Freeze set (as RUN rule 1) is asserted every cycle that mem_wait=1; wait counter increments.
  - The cycle MEM_MemReady=1 (or MEM_MemReq drops), freeze is released in that same cycle and RUN priority rules apply combinationally. Next state RUN, wait counter=0.
  - A branch or load-use pending under freeze is therefore serviced on the release cycle.
  - If mem_wait is still 1 when wait counter==TIMEOUT: next state HALT, mem_timeout=1.
- HALT: freeze set asserted unconditionally; mem_timeout stays 1; the only exit is rst.
- mem_stall_cnt increments on every cycle the freeze set is asserted, including HALT.
- Counters saturate at 2^CNT_W-1. cnt_clear has priority over increments and does not affect state or mem_timeout.
- EX_Rd==0 never triggers load_use. Equal ID_Rs1 and ID_Rs2 count as one bubble.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd=3, ID_Rs2=3, ID_UsesRs2=1 for one cycle -> pc_hold=ifid_hold=idex_bubble=1 that cycle only; load_use_cnt=1. Same with EX_Rd=0 -> all controls 0.
- Branch vs load-use: EX_BranchTaken=1 together with a load-use match on Rs1=5 -> ifid_flush=idex_bubble=1, pc_hold=0; flush_cnt=1, load_use_cnt=0.
- Memory wait: MEM_MemReq=1, MEM_MemReady=0 for 3 cycles then MEM_MemReady=1 -> freeze set asserted 3 cycles, released on the ready cycle; mem_stall_cnt=3; state RUN.
- Branch under freeze: EX_BranchTaken=1 held through a 2-cycle wait -> no flush during freeze; flush asserted on release cycle; flush_cnt=1.
- Timeout: TIMEOUT=4, ready never asserted -> mem_timeout=1 after the 4th wait cycle, freeze held indefinitely; async rst mid-HALT -> all outputs 0 immediately, RUN after release.
- Counter clear/saturation: CNT_W=2, force 5 load-use events -> load_use_cnt=3; cnt_clear=1 coinciding with an event -> 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Stall/flush companion to the ALU forwarding unit. Resolves the hazards
//   forwarding cannot: load-use bubbles, data-memory wait freezes and
//   taken-branch flushes. Includes a memory-wait watchdog and saturating
//   hazard performance counters.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ID_Rs1/ID_Rs2            source registers of the ID instruction
//   ID_UsesRs1/ID_UsesRs2    ID instruction actually reads Rs1/Rs2
//   EX_MemRead, EX_Rd        EX instruction is a load / its destination
//   EX_BranchTaken           EX resolved a taken branch or jump
//   MEM_MemReq, MEM_MemReady data-memory access active / completes this cycle
//   cnt_clear                synchronous clear of the performance counters
//   pc_hold .. memwb_bubble  pipeline register controls (combinational)
//   mem_timeout              sticky watchdog error
//   load_use_cnt, mem_stall_cnt, flush_cnt  saturating event counters
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_Rs2,
  input  logic                  ID_UsesRs1,
  input  logic                  ID_UsesRs2,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  EX_BranchTaken,
  input  logic                  MEM_MemReq,
  input  logic                  MEM_MemReady,
  input  logic                  cnt_clear,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  ifid_flush,
  output logic                  idex_hold,
  output logic                  idex_bubble,
  output logic                  exmem_hold,
  output logic                  memwb_bubble,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      load_use_cnt,
  output logic [CNT_W-1:0]      mem_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  // wait_cnt holds the number of wait cycles already completed, so the
  // current cycle is wait number wait_cnt+1; the watchdog fires at the end
  // of wait cycle TIMEOUT.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        timeout_nxt;
  logic        load_use, mem_wait;
  logic        freeze, flush_evt, lu_evt;

  assign load_use = EX_MemRead && (EX_Rd != '0) &&
                    ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                     (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));
  assign mem_wait = MEM_MemReq && !MEM_MemReady;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = mem_timeout;
    freeze       = 1'b0;
    flush_evt    = 1'b0;
    lu_evt       = 1'b0;
    case (state)
      S_RUN, S_MEM_WAIT: begin
        if (mem_wait) begin
          freeze = 1'b1;
          if (state == S_RUN) begin
            state_nxt    = S_MEM_WAIT;
            wait_cnt_nxt = 16'd1;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt   = S_HALT;
            timeout_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 16'd1;
          end
        end else begin
          // Release cycle of a freeze behaves exactly like RUN, so a branch
          // or load-use held behind the freeze is serviced right here.
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
          if (EX_BranchTaken) flush_evt = 1'b1;
          else if (load_use)  lu_evt    = 1'b1;
        end
      end
      S_HALT: freeze = 1'b1;
      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
    if (rst) begin
      freeze    = 1'b0;
      flush_evt = 1'b0;
      lu_evt    = 1'b0;
    end
  end

  assign pc_hold      = freeze | lu_evt;
  assign ifid_hold    = freeze | lu_evt;
  assign ifid_flush   = flush_evt;
  assign idex_hold    = freeze;
  assign idex_bubble  = flush_evt | lu_evt;
  assign exmem_hold   = freeze;
  assign memwb_bubble = freeze;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_use_cnt  <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else if (cnt_clear) begin
      load_use_cnt  <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (lu_evt)    load_use_cnt  <= sat_inc(load_use_cnt);
      if (freeze)    mem_stall_cnt <= sat_inc(mem_stall_cnt);
      if (flush_evt) flush_cnt     <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int RW = 5;
  localparam int TO = 4;
  localparam int CW = 2;

  // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b1101011;
  localparam logic [6:0] C_BR     = 7'b0010100;
  localparam logic [6:0] C_LU     = 7'b1100100;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] ID_Rs1, ID_Rs2, EX_Rd;
  logic          ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken;
  logic          MEM_MemReq, MEM_MemReady, cnt_clear;
  logic          pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble;
  logic          exmem_hold, memwb_bubble, mem_timeout;
  logic [CW-1:0] load_use_cnt, mem_stall_cnt, flush_cnt;
  logic [6:0]    ctrl;

  pipeline_hazard_controller #(
    .REG_ADDR_W(RW),
    .TIMEOUT   (TO),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ID_Rs1        (ID_Rs1),
    .ID_Rs2        (ID_Rs2),
    .ID_UsesRs1    (ID_UsesRs1),
    .ID_UsesRs2    (ID_UsesRs2),
    .EX_MemRead    (EX_MemRead),
    .EX_Rd         (EX_Rd),
    .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemReq    (MEM_MemReq),
    .MEM_MemReady  (MEM_MemReady),
    .cnt_clear     (cnt_clear),
    .pc_hold       (pc_hold),
    .ifid_hold     (ifid_hold),
    .ifid_flush    (ifid_flush),
    .idex_hold     (idex_hold),
    .idex_bubble   (idex_bubble),
    .exmem_hold    (exmem_hold),
    .memwb_bubble  (memwb_bubble),
    .mem_timeout   (mem_timeout),
    .load_use_cnt  (load_use_cnt),
    .mem_stall_cnt (mem_stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  assign ctrl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
                 exmem_hold, memwb_bubble};

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [6:0] ctrl;
  } exp_t;

  exp_t sb[$];

  // expected counter / watchdog values as of the current cycle
  logic [CW-1:0] m_lu, m_st, m_fl;
  logic          m_to;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  task automatic idle();
    ID_Rs1 = '0; ID_Rs2 = '0; EX_Rd = '0;
    ID_UsesRs1 = 0; ID_UsesRs2 = 0; EX_MemRead = 0; EX_BranchTaken = 0;
    MEM_MemReq = 0; MEM_MemReady = 0; cnt_clear = 0;
  endtask

  task automatic model_reset();
    m_lu = '0; m_st = '0; m_fl = '0; m_to = 1'b0;
  endtask

  // Inputs are already driven (1 time unit after posedge). Expected controls
  // are queued now and compared against the DUT on the following negedge.
  task automatic step(input string tag, input logic [6:0] exp_ctrl);
    exp_t it;
    sb.push_back('{tag, exp_ctrl});
    @(negedge clk);
    it = sb.pop_front();
    check(it.tag, ctrl, it.ctrl);
    check({it.tag, "_lu_cnt"}, load_use_cnt, m_lu);
    check({it.tag, "_stall_cnt"}, mem_stall_cnt, m_st);
    check({it.tag, "_flush_cnt"}, flush_cnt, m_fl);
    check({it.tag, "_timeout"}, mem_timeout, m_to);
    if (cnt_clear) begin
      m_lu = '0; m_st = '0; m_fl = '0;
    end else begin
      if (it.ctrl == C_LU)     m_lu = sat(m_lu);
      if (it.ctrl == C_FREEZE) m_st = sat(m_st);
      if (it.ctrl == C_BR)     m_fl = sat(m_fl);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnts();
    idle();
    cnt_clear = 1;
    step("clear", C_NONE);
    cnt_clear = 0;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    MEM_MemReq = 1;            // a live hazard must still be masked in reset
    #2;
    check("reset_ctrl", ctrl, C_NONE);
    check("reset_lu_cnt", load_use_cnt, 0);
    check("reset_timeout", mem_timeout, 0);
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;

    // load-use on Rs2
    EX_MemRead = 1; EX_Rd = 5'd3; ID_Rs2 = 5'd3; ID_UsesRs2 = 1;
    step("lu_rs2", C_LU);
    idle();
    step("lu_done", C_NONE);
    check("lu_cnt_one", load_use_cnt, 1);
    // EX_Rd == 0 never stalls
    EX_MemRead = 1; EX_Rd = '0; ID_Rs2 = '0; ID_UsesRs2 = 1;
    step("lu_rd0", C_NONE);
    // match on Rs1 but Rs1 unused
    EX_MemRead = 1; EX_Rd = 5'd9; ID_Rs1 = 5'd9; ID_UsesRs1 = 0;
    step("lu_unused", C_NONE);
    // not a load
    EX_MemRead = 0; ID_UsesRs1 = 1;
    step("lu_notload", C_NONE);
    // both sources equal to EX_Rd: one bubble
    EX_MemRead = 1; EX_Rd = 5'd7; ID_Rs1 = 5'd7; ID_Rs2 = 5'd7;
    ID_UsesRs1 = 1; ID_UsesRs2 = 1;
    step("lu_both", C_LU);
    idle();
    step("lu_both_done", C_NONE);
    check("lu_cnt_two", load_use_cnt, 2);

    // branch beats load-use
    clear_cnts();
    EX_BranchTaken = 1; EX_MemRead = 1; EX_Rd = 5'd5; ID_Rs1 = 5'd5; ID_UsesRs1 = 1;
    step("br_vs_lu", C_BR);
    idle();
    step("br_done", C_NONE);
    check("br_flush_cnt", flush_cnt, 1);
    check("br_lu_cnt", load_use_cnt, 0);

    // memory wait 3 cycles then ready
    clear_cnts();
    MEM_MemReq = 1;
    for (int unsigned i = 0; i < 3; i++) step("mw_freeze", C_FREEZE);
    MEM_MemReady = 1;
    step("mw_release", C_NONE);
    idle();
    step("mw_done", C_NONE);
    check("mw_stall_cnt", mem_stall_cnt, 3);
    // back in RUN: a load-use is serviced normally
    EX_MemRead = 1; EX_Rd = 5'd4; ID_Rs1 = 5'd4; ID_UsesRs1 = 1;
    step("mw_run_lu", C_LU);
    idle();

    // branch held through a 2-cycle freeze
    clear_cnts();
    EX_BranchTaken = 1; MEM_MemReq = 1;
    step("bf_freeze0", C_FREEZE);
    step("bf_freeze1", C_FREEZE);
    MEM_MemReady = 1;
    step("bf_release", C_BR);
    idle();
    step("bf_done", C_NONE);
    check("bf_flush_cnt", flush_cnt, 1);

    // load-use held through a freeze; request dropping also releases
    EX_MemRead = 1; EX_Rd = 5'd12; ID_Rs2 = 5'd12; ID_UsesRs2 = 1; MEM_MemReq = 1;
    step("lf_freeze", C_FREEZE);
    MEM_MemReq = 0;
    step("lf_release", C_LU);
    idle();
    step("lf_done", C_NONE);

    // saturation and clear priority
    clear_cnts();
    EX_MemRead = 1; EX_Rd = 5'd2; ID_Rs1 = 5'd2; ID_UsesRs1 = 1;
    for (int unsigned i = 0; i < 5; i++) step("sat_lu", C_LU);
    check("sat_lu_cnt", load_use_cnt, 3);
    cnt_clear = 1;
    step("clr_with_evt", C_LU);
    idle();
    step("clr_done", C_NONE);
    check("clr_lu_cnt", load_use_cnt, 0);

    // watchdog: ready never comes
    MEM_MemReq = 1;
    for (int unsigned i = 0; i < 4; i++) step("to_wait", C_FREEZE);
    m_to = 1'b1;
    step("to_halt", C_FREEZE);
    check("to_flag", mem_timeout, 1);
    MEM_MemReady = 1;
    step("to_halt_ready", C_FREEZE);
    idle();
    EX_BranchTaken = 1;
    step("to_halt_idle", C_FREEZE);
    idle();
    cnt_clear = 1;
    step("to_halt_clear", C_FREEZE);
    cnt_clear = 0;
    step("to_halt_after_clear", C_FREEZE);
    check("to_flag_sticky", mem_timeout, 1);

    // asynchronous reset in HALT
    MEM_MemReq = 1;
    rst = 1;
    #1;
    check("arst_ctrl", ctrl, C_NONE);
    check("arst_timeout", mem_timeout, 0);
    check("arst_stall_cnt", mem_stall_cnt, 0);
    idle();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    EX_MemRead = 1; EX_Rd = 5'd6; ID_Rs2 = 5'd6; ID_UsesRs2 = 1;
    step("arst_run_lu", C_LU);
    idle();
    step("arst_idle", C_NONE);
    // watchdog restarts from zero after reset
    MEM_MemReq = 1;
    for (int unsigned i = 0; i < 3; i++) step("arst_wait", C_FREEZE);
    MEM_MemReady = 1;
    step("arst_release", C_NONE);
    idle();
    step("arst_final", C_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
